// File: rtl/mul_hilo_pkg.sv
// Shared definitions for the HI/LO multiply controller: op codes, FSM states, accumulate modes.
// The optional accumulate ops are enabled by defining MUL_HILO_ACC_EN.
package mul_hilo_pkg;

    localparam logic [2:0] OP_MULT  = 3'd0;
    localparam logic [2:0] OP_MULTU = 3'd1;
    localparam logic [2:0] OP_MTHI  = 3'd2;
    localparam logic [2:0] OP_MTLO  = 3'd3;
    localparam logic [2:0] OP_MADD  = 3'd4;
    localparam logic [2:0] OP_MADDU = 3'd5;
    localparam logic [2:0] OP_MSUB  = 3'd6;
    localparam logic [2:0] OP_MSUBU = 3'd7;

    localparam int MUL_LAT_MAX = 8;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        ACC_LOAD = 2'd0,
        ACC_ADD  = 2'd1,
        ACC_SUB  = 2'd2
    } acc_t;

    // Ops 4/5 accumulate, 6/7 subtract; everything else is a plain product load.
    function automatic acc_t acc_of(input logic [2:0] op);
        if (!op[2])
            return ACC_LOAD;
        return op[1] ? ACC_SUB : ACC_ADD;
    endfunction

endpackage

// File: rtl/hilo_reg.sv
// 64-bit HI/LO register pair with independent HI/LO writes and a product write port.
// With MUL_HILO_ACC_EN defined, the product write can add to or subtract from the current {hi,lo}.
module hilo_reg
    import mul_hilo_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_hi,
    input  logic        wr_lo,
    input  logic        wr_prod,
    input  acc_t        acc_mode,
    input  logic [31:0] din,
    input  logic [63:0] prod,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    logic [63:0] prod_val;

`ifdef MUL_HILO_ACC_EN
    // Modulo-2^64 accumulate, evaluated in the commit cycle.
    always_comb begin
        prod_val = prod;
        case (acc_mode)
            ACC_ADD: prod_val = {hi, lo} + prod;
            ACC_SUB: prod_val = {hi, lo} - prod;
            default: prod_val = prod;
        endcase
    end
`else
    logic unused_acc;
    assign unused_acc = ^acc_mode;
    assign prod_val   = prod;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hi <= '0;
            lo <= '0;
        end else if (wr_prod) begin
            {hi, lo} <= prod_val;
        end else begin
            if (wr_hi)
                hi <= din;
            if (wr_lo)
                lo <= din;
        end
    end

endmodule

// File: rtl/mul_hilo_ctrl.sv
// Multiplier sequencer and HI/LO owner: registers operands, counts MUL_LAT cycles, commits the product.
// Defining MUL_HILO_ACC_EN turns ops 4-7 into multiply-accumulate/subtract; otherwise they are dropped.
module mul_hilo_ctrl
    import mul_hilo_pkg::*;
#(
    parameter  int MUL_LAT = 2,
    localparam int CNT_W   = $clog2(MUL_LAT + 1)
) (
    input  logic        mul_clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [31:0] req_x,
    input  logic [31:0] req_y,
    input  logic        flush,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    output logic        mul_signed,
    input  logic [63:0] mul_result,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        hilo_busy,
    output logic        done,
    output state_t      dbg_state
);

    state_t           state, next_state;
    logic [CNT_W-1:0] cnt, cnt_next;
    acc_t             pend_acc;
    logic             accept, is_mul, start, commit;

    // Handshake: an op transfers on an edge where req_valid & req_ready are both high and flush is
    // low; req_ready depends only on state (and reset), never on req_valid, and the EX stage holds
    // its request stable until that transfer edge.
    assign req_ready = (state == ST_IDLE) & ~reset;
    assign accept    = req_valid & req_ready & ~flush;
    assign hilo_busy = (state == ST_BUSY);
    assign dbg_state = state;

`ifdef MUL_HILO_ACC_EN
    assign is_mul = (req_op == OP_MULT) | (req_op == OP_MULTU) | req_op[2];
`else
    assign is_mul = (req_op == OP_MULT) | (req_op == OP_MULTU);
`endif
    assign start = accept & is_mul;

    always_comb begin
        next_state = state;
        cnt_next   = cnt;
        commit     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    next_state = ST_BUSY;
                    cnt_next   = CNT_W'(MUL_LAT);
                end
            end
            ST_BUSY: begin
                // A flush on the final count still cancels the write.
                if (flush) begin
                    next_state = ST_IDLE;
                    cnt_next   = '0;
                end else if (cnt == CNT_W'(1)) begin
                    next_state = ST_IDLE;
                    cnt_next   = '0;
                    commit     = 1'b1;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            default: begin
                next_state = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge mul_clk or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            cnt        <= '0;
            done       <= 1'b0;
            mul_x      <= '0;
            mul_y      <= '0;
            mul_signed <= 1'b0;
            pend_acc   <= ACC_LOAD;
        end else begin
            state <= next_state;
            cnt   <= cnt_next;
            done  <= commit;
            if (start) begin
                mul_x      <= req_x;
                mul_y      <= req_y;
                mul_signed <= ~req_op[0];
                pend_acc   <= acc_of(req_op);
            end
        end
    end

    hilo_reg u_hilo (
        .clk      (mul_clk),
        .rst      (reset),
        .wr_hi    (accept & (req_op == OP_MTHI)),
        .wr_lo    (accept & (req_op == OP_MTLO)),
        .wr_prod  (commit),
        .acc_mode (pend_acc),
        .din      (req_x),
        .prod     (mul_result),
        .hi       (hi),
        .lo       (lo)
    );

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed bench for mul_hilo_ctrl (MUL_LAT=2); the multiplier is emulated combinationally.
// The accumulate scenario follows MUL_HILO_ACC_EN when it is defined for the build.
module tb_mul_hilo_ctrl;
  import mul_hilo_pkg::*;

  logic        mul_clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_x = '0;
  logic [31:0] req_y = '0;
  logic        flush = 1'b0;
  logic [31:0] mul_x, mul_y;
  logic        mul_signed;
  logic [63:0] mul_result;
  logic [31:0] hi, lo;
  logic        hilo_busy, done;
  state_t      dbg_state;
  logic [63:0] ext_x, ext_y;

  int checks = 0;
  int errors = 0;

  always #5 mul_clk = ~mul_clk;

  // Multiplier stand-in: operands are held stable, so a combinational product is cycle-equivalent.
  assign ext_x = mul_signed ? {{32{mul_x[31]}}, mul_x} : {32'b0, mul_x};
  assign ext_y = mul_signed ? {{32{mul_y[31]}}, mul_y} : {32'b0, mul_y};
  assign mul_result = ext_x * ext_y;

  mul_hilo_ctrl #(.MUL_LAT(2)) dut (
    .mul_clk    (mul_clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_x      (req_x),
    .req_y      (req_y),
    .flush      (flush),
    .mul_x      (mul_x),
    .mul_y      (mul_y),
    .mul_signed (mul_signed),
    .mul_result (mul_result),
    .hi         (hi),
    .lo         (lo),
    .hilo_busy  (hilo_busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  task automatic test_reset;
    #12;
    checks++; if (hi !== 32'h0) begin errors++; $display("FAIL rst_hi got %h exp %h", hi, 32'h0); end
    checks++; if (lo !== 32'h0) begin errors++; $display("FAIL rst_lo got %h exp %h", lo, 32'h0); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", done); end
    checks++; if (hilo_busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", hilo_busy); end
    checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_ready got %b exp 0", req_ready); end
    checks++; if (mul_x !== 32'h0 || mul_signed !== 1'b0) begin errors++; $display("FAIL rst_mul got %h/%b exp 0/0", mul_x, mul_signed); end
    checks++; if (dbg_state !== ST_IDLE) begin errors++; $display("FAIL rst_state got %0d exp %0d", dbg_state, ST_IDLE); end
    @(negedge mul_clk); reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_release_ready got %b exp 1", req_ready); end
    @(posedge mul_clk); #1;
  endtask

  task automatic test_mult_signed;
    req_valid = 1'b1; req_op = OP_MULT; req_x = 32'hFFFF_FFFD; req_y = 32'd7;
    @(posedge mul_clk); #1; req_valid = 1'b0;
    checks++; if (mul_signed !== 1'b1) begin errors++; $display("FAIL mult_signed got %b exp 1", mul_signed); end
    checks++; if (mul_x !== 32'hFFFF_FFFD || mul_y !== 32'd7) begin errors++; $display("FAIL mult_operands got %h/%h exp fffffffd/00000007", mul_x, mul_y); end
    checks++; if (hilo_busy !== 1'b1 || dbg_state !== ST_BUSY) begin errors++; $display("FAIL mult_busy1 got %b/%0d exp 1/1", hilo_busy, dbg_state); end
    @(posedge mul_clk); #1;
    checks++; if (hilo_busy !== 1'b1 || done !== 1'b0) begin errors++; $display("FAIL mult_busy2 got %b/%b exp 1/0", hilo_busy, done); end
    @(posedge mul_clk); #1;
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_hilo got %h:%h exp ffffffff:ffffffeb", hi, lo); end
    checks++; if (done !== 1'b1 || hilo_busy !== 1'b0) begin errors++; $display("FAIL mult_done got %b/%b exp 1/0", done, hilo_busy); end
    @(posedge mul_clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mult_done_pulse got %b exp 0", done); end
  endtask

  task automatic test_back_to_back;
    req_valid = 1'b1; req_op = OP_MULTU; req_x = 32'hFFFF_FFFF; req_y = 32'hFFFF_FFFF;
    @(posedge mul_clk); #1;
    req_op = OP_MTLO; req_x = 32'h5555_5555;
    checks++; if (req_ready !== 1'b0 || mul_signed !== 1'b0) begin errors++; $display("FAIL b2b_ready1 got %b/%b exp 0/0", req_ready, mul_signed); end
    @(posedge mul_clk); #1;
    checks++; if (req_ready !== 1'b0 || lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL b2b_ready2 got %b/%h exp 0/ffffffeb", req_ready, lo); end
    @(posedge mul_clk); #1;
    checks++; if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_hilo got %h:%h exp fffffffe:00000001", hi, lo); end
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready3 got %b exp 1", req_ready); end
    @(posedge mul_clk); #1; req_valid = 1'b0;
    checks++; if (lo !== 32'h5555_5555 || hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL b2b_held got %h:%h exp fffffffe:55555555", hi, lo); end
    checks++; if (hilo_busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL b2b_idle got %b/%b exp 0/0", hilo_busy, done); end
  endtask

  task automatic test_move;
    req_valid = 1'b1; req_op = OP_MTHI; req_x = 32'h1234_5678;
    @(posedge mul_clk); #1;
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL mthi got %h exp 12345678", hi); end
    checks++; if (hilo_busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL mthi_idle got %b/%b exp 0/1", hilo_busy, req_ready); end
    req_op = OP_MTLO; req_x = 32'h9ABC_DEF0;
    @(posedge mul_clk); #1; req_valid = 1'b0;
    checks++; if (lo !== 32'h9ABC_DEF0 || hi !== 32'h1234_5678) begin errors++; $display("FAIL mtlo got %h:%h exp 12345678:9abcdef0", hi, lo); end
    checks++; if (done !== 1'b0 || hilo_busy !== 1'b0) begin errors++; $display("FAIL mtlo_done got %b/%b exp 0/0", done, hilo_busy); end
  endtask

  task automatic test_flush;
    req_valid = 1'b1; req_op = OP_MULT; req_x = 32'd5; req_y = 32'd6;
    @(posedge mul_clk); #1; req_valid = 1'b0;
    @(posedge mul_clk); #1; flush = 1'b1;
    @(posedge mul_clk); #1; flush = 1'b0;
    checks++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL flush_commit_hilo got %h:%h exp 12345678:9abcdef0", hi, lo); end
    checks++; if (done !== 1'b0 || hilo_busy !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL flush_commit_state got %b/%b/%0d exp 0/0/0", done, hilo_busy, dbg_state); end
    @(posedge mul_clk); #1;
    checks++; if (done !== 1'b0 || lo !== 32'h9ABC_DEF0) begin errors++; $display("FAIL flush_commit_after got %b/%h exp 0/9abcdef0", done, lo); end
    req_valid = 1'b1;
    @(posedge mul_clk); #1; req_valid = 1'b0; flush = 1'b1;
    @(posedge mul_clk); #1; flush = 1'b0;
    checks++; if (hilo_busy !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL flush_early_state got %b/%b exp 0/1", hilo_busy, req_ready); end
    @(posedge mul_clk); #1;
    checks++; if (hi !== 32'h1234_5678 || lo !== 32'h9ABC_DEF0 || done !== 1'b0) begin errors++; $display("FAIL flush_early_hilo got %h:%h/%b exp 12345678:9abcdef0/0", hi, lo, done); end
    req_valid = 1'b1; req_op = OP_MTHI; req_x = 32'hDEAD_BEEF; flush = 1'b1;
    @(posedge mul_clk); #1; req_valid = 1'b0; flush = 1'b0;
    checks++; if (hi !== 32'h1234_5678) begin errors++; $display("FAIL flush_idle_block got %h exp 12345678", hi); end
  endtask

  task automatic test_async_reset;
    req_valid = 1'b1; req_op = OP_MULT; req_x = 32'd5; req_y = 32'd6;
    @(posedge mul_clk); #1; req_valid = 1'b0;
    @(posedge mul_clk); #3; reset = 1'b1;
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h0) begin errors++; $display("FAIL arst_hilo got %h:%h exp 0:0", hi, lo); end
    checks++; if (done !== 1'b0 || hilo_busy !== 1'b0 || req_ready !== 1'b0) begin errors++; $display("FAIL arst_ctrl got %b/%b/%b exp 0/0/0", done, hilo_busy, req_ready); end
    @(posedge mul_clk); @(negedge mul_clk); reset = 1'b0;
    #1;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL arst_ready got %b exp 1", req_ready); end
    repeat (3) @(posedge mul_clk);
    #1;
    checks++; if (lo !== 32'h0 || done !== 1'b0 || hilo_busy !== 1'b0) begin errors++; $display("FAIL arst_no_commit got %h/%b/%b exp 0/0/0", lo, done, hilo_busy); end
  endtask

  task automatic test_accumulate;
    req_valid = 1'b1; req_op = OP_MTHI; req_x = 32'h0;
    @(posedge mul_clk); #1; req_op = OP_MTLO; req_x = 32'h10;
    @(posedge mul_clk); #1; req_op = OP_MADD; req_x = 32'd3; req_y = 32'd4;
    @(posedge mul_clk); #1; req_valid = 1'b0;
`ifdef MUL_HILO_ACC_EN
    checks++; if (hilo_busy !== 1'b1 || mul_signed !== 1'b1) begin errors++; $display("FAIL madd_busy got %b/%b exp 1/1", hilo_busy, mul_signed); end
    repeat (2) @(posedge mul_clk);
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h1C || done !== 1'b1) begin errors++; $display("FAIL madd_hilo got %h:%h/%b exp 00000000:0000001c/1", hi, lo, done); end
    req_valid = 1'b1; req_op = OP_MSUB; req_x = 32'd2; req_y = 32'h10;
    @(posedge mul_clk); #1; req_valid = 1'b0;
    repeat (2) @(posedge mul_clk);
    #1;
    checks++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFC || done !== 1'b1) begin errors++; $display("FAIL msub_hilo got %h:%h/%b exp ffffffff:fffffffc/1", hi, lo, done); end
`else
    checks++; if (hilo_busy !== 1'b0 || dbg_state !== ST_IDLE) begin errors++; $display("FAIL madd_drop_state got %b/%0d exp 0/0", hilo_busy, dbg_state); end
    repeat (2) @(posedge mul_clk);
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h10 || done !== 1'b0) begin errors++; $display("FAIL madd_drop_hilo got %h:%h/%b exp 00000000:00000010/0", hi, lo, done); end
    req_valid = 1'b1; req_op = OP_MSUB; req_x = 32'd2; req_y = 32'h10;
    @(posedge mul_clk); #1; req_valid = 1'b0;
    repeat (2) @(posedge mul_clk);
    #1;
    checks++; if (hi !== 32'h0 || lo !== 32'h10 || done !== 1'b0) begin errors++; $display("FAIL msub_drop_hilo got %h:%h/%b exp 00000000:00000010/0", hi, lo, done); end
`endif
  endtask

  initial begin
    test_reset();
    test_mult_signed();
    test_back_to_back();
    test_move();
    test_flush();
    test_async_reset();
    test_accumulate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
